// File: rtl/i2c_read_scheduler.sv
// i2c_read_scheduler: shares one single-transaction I2C register-read engine
// between NUM_REQ requesters. Round-robin grant, one read per grant, a
// timeout abort if the engine never completes, and an enforced idle gap on
// the bus before the next grant.
module i2c_read_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_DATA_BYTES = 2,
  parameter int GAP_CYCLES     = 60,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [7*NUM_REQ-1:0]        req_dev_addr,
  input  logic [8*NUM_REQ-1:0]        req_reg_addr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic                        resp_error,
  output logic [8*NUM_DATA_BYTES-1:0] resp_data,
  output logic                        eng_start,
  output logic [6:0]                  eng_dev_addr,
  output logic [7:0]                  eng_reg_addr,
  input  logic                        eng_busy,
  input  logic                        eng_done,
  input  logic                        eng_nack,
  input  logic [8*NUM_DATA_BYTES-1:0] eng_data,
  output logic                        eng_abort,
  output logic [1:0]                  state_out
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int DATA_W = 8 * NUM_DATA_BYTES;
  localparam logic [IDX_W:0]   NUM_REQ_W    = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [15:0]         tmo_cnt_reg, tmo_cnt_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [NUM_REQ-1:0]  resp_valid_reg, resp_valid_next;
  logic                resp_error_reg, resp_error_next;
  logic [DATA_W-1:0]   resp_data_reg, resp_data_next;
  logic                eng_start_reg, eng_start_next;
  logic                eng_abort_reg, eng_abort_next;
  logic [6:0]          dev_addr_reg, dev_addr_next;
  logic [7:0]          reg_addr_reg, reg_addr_next;

  logic [IDX_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_req;
  logic [6:0]          dev_arr  [NUM_REQ];
  logic [7:0]          reg_arr  [NUM_REQ];
  logic [IDX_W-1:0]    sel_idx;
  logic                txn_end;

  // Candidate gi is the requester gi places above the round-robin pointer,
  // wrapped at NUM_REQ (which need not be a power of two).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDX_W:0] offset_sum;
      assign offset_sum   = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (offset_sum >= NUM_REQ_W) ? IDX_W'(offset_sum - NUM_REQ_W)
                                                      : IDX_W'(offset_sum);
      assign cand_req[gi] = req[cand_idx[gi]];
      assign dev_arr[gi]  = req_dev_addr[7*gi +: 7];
      assign reg_arr[gi]  = req_reg_addr[8*gi +: 8];
    end
  endgenerate

  // Pick the active request closest to the pointer (smallest offset wins).
  always_comb begin
    sel_idx = rr_ptr_reg;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        sel_idx = cand_idx[i];
      end
    end
  end

  // Next-state and registered-output logic for the grant/issue/wait/gap sequence.
  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    idx_next        = idx_reg;
    gap_cnt_next    = gap_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    grant_next      = grant_reg;
    resp_valid_next = '0;
    resp_error_next = resp_error_reg;
    resp_data_next  = resp_data_reg;
    eng_start_next  = 1'b0;
    eng_abort_next  = 1'b0;
    dev_addr_next   = dev_addr_reg;
    reg_addr_next   = reg_addr_reg;
    txn_end         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          idx_next            = sel_idx;
          dev_addr_next       = dev_arr[sel_idx];
          reg_addr_next       = reg_arr[sel_idx];
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
          state_next          = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Only start once the engine reports it is free.
        if (!eng_busy) begin
          eng_start_next = 1'b1;
          tmo_cnt_next   = '0;
          state_next     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tmo_cnt_next = tmo_cnt_reg + 16'd1;
        // A completion arriving on the timeout cycle still counts as completion.
        if (eng_done) begin
          resp_data_next  = eng_data;
          resp_error_next = eng_nack;
          txn_end         = 1'b1;
        end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
          eng_abort_next  = 1'b1;
          resp_data_next  = '0;
          resp_error_next = 1'b1;
          txn_end         = 1'b1;
        end
        if (txn_end) begin
          resp_valid_next          = '0;
          resp_valid_next[idx_reg] = 1'b1;
          grant_next               = '0;
          rr_ptr_next              = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          gap_cnt_next             = '0;
          state_next               = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset leaves the engine alone (it shares reset).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= '0;
      idx_reg        <= '0;
      gap_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      grant_reg      <= '0;
      resp_valid_reg <= '0;
      resp_error_reg <= 1'b0;
      resp_data_reg  <= '0;
      eng_start_reg  <= 1'b0;
      eng_abort_reg  <= 1'b0;
      dev_addr_reg   <= '0;
      reg_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      idx_reg        <= idx_next;
      gap_cnt_reg    <= gap_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      grant_reg      <= grant_next;
      resp_valid_reg <= resp_valid_next;
      resp_error_reg <= resp_error_next;
      resp_data_reg  <= resp_data_next;
      eng_start_reg  <= eng_start_next;
      eng_abort_reg  <= eng_abort_next;
      dev_addr_reg   <= dev_addr_next;
      reg_addr_reg   <= reg_addr_next;
    end
  end

  assign grant        = grant_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_error   = resp_error_reg;
  assign resp_data    = resp_data_reg;
  assign eng_start    = eng_start_reg;
  assign eng_abort    = eng_abort_reg;
  assign eng_dev_addr = dev_addr_reg;
  assign eng_reg_addr = reg_addr_reg;
  assign state_out    = state_reg;

endmodule

// File: tb/tb_i2c_read_scheduler.sv
// Bench for i2c_read_scheduler. Instance A (4 requesters, gap 60, default
// timeout) is checked every cycle against a transaction-timeline model plus
// literal expectations; instance B (3 requesters, gap 0, timeout 100) covers
// timeout, done/timeout collision and non-power-of-two wrap with literals.
`timescale 1ns/1ps
module tb_i2c_read_scheduler;

  localparam int N    = 4;
  localparam int GAP  = 60;
  localparam int TMO  = 65535;
  localparam int DW   = 16;
  localparam int NB   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_dev_addr = '0;
  logic [8*N-1:0] req_reg_addr = '0;
  logic [N-1:0]   grant, resp_valid;
  logic           resp_error;
  logic [DW-1:0]  resp_data;
  logic           eng_start, eng_abort;
  logic [6:0]     eng_dev_addr;
  logic [7:0]     eng_reg_addr;
  logic           eng_busy = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;
  logic [DW-1:0]  eng_data = '0;
  logic [1:0]     state_out;

  i2c_read_scheduler #(.NUM_REQ(N), .NUM_DATA_BYTES(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clock(clock), .reset(reset), .req(req), .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr), .grant(grant), .resp_valid(resp_valid),
    .resp_error(resp_error), .resp_data(resp_data), .eng_start(eng_start),
    .eng_dev_addr(eng_dev_addr), .eng_reg_addr(eng_reg_addr), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_data(eng_data),
    .eng_abort(eng_abort), .state_out(state_out)
  );

  // ---------------- instance B ----------------
  logic [NB-1:0]   req_b = '0;
  logic [7*NB-1:0] req_dev_addr_b = '0;
  logic [8*NB-1:0] req_reg_addr_b = '0;
  logic [NB-1:0]   grant_b, resp_valid_b;
  logic            resp_error_b;
  logic [DW-1:0]   resp_data_b;
  logic            eng_start_b, eng_abort_b;
  logic [6:0]      eng_dev_addr_b;
  logic [7:0]      eng_reg_addr_b;
  logic            eng_busy_b = 1'b0, eng_done_b = 1'b0, eng_nack_b = 1'b0;
  logic [DW-1:0]   eng_data_b = '0;
  logic [1:0]      state_out_b;

  i2c_read_scheduler #(.NUM_REQ(NB), .NUM_DATA_BYTES(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .req_dev_addr(req_dev_addr_b),
    .req_reg_addr(req_reg_addr_b), .grant(grant_b), .resp_valid(resp_valid_b),
    .resp_error(resp_error_b), .resp_data(resp_data_b), .eng_start(eng_start_b),
    .eng_dev_addr(eng_dev_addr_b), .eng_reg_addr(eng_reg_addr_b), .eng_busy(eng_busy_b),
    .eng_done(eng_done_b), .eng_nack(eng_nack_b), .eng_data(eng_data_b),
    .eng_abort(eng_abort_b), .state_out(state_out_b)
  );

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit probe(int sel);
    case (sel)
      0: return eng_start === 1'b1;
      1: return (|resp_valid) === 1'b1;
      2: return (|grant) === 1'b1;
      3: return eng_start_b === 1'b1;
      4: return (|resp_valid_b) === 1'b1;
      5: return eng_abort_b === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Polls at negedges until the selected event is seen or the budget expires.
  task automatic wait_for(int sel, int budget, string name);
    int n = 0;
    while (!probe(sel) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!probe(sel)) begin
      failures++;
      $display("FAIL %s: event not seen within %0d cycles (cycle %0d)", name, budget, cyc);
    end
  endtask

  function automatic int onehot_idx(logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- model of instance A ----------------
  logic [N-1:0]  m_grant = '0, m_rv = '0;
  logic          m_err = 1'b0, m_start = 1'b0, m_abort = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [6:0]    m_dev = '0;
  logic [7:0]    m_reg = '0;
  logic [1:0]    m_state = 2'd0;
  int            m_ptr = 0;

  // Advance one clock; pulses last one cycle; reset wipes everything.
  task automatic m_tick(output bit r);
    @(posedge clock);
    m_start = 1'b0;
    m_abort = 1'b0;
    m_rv    = '0;
    r = reset;
    if (reset) begin
      m_grant = '0; m_err = 1'b0; m_data = '0; m_dev = '0; m_reg = '0;
      m_state = 2'd0; m_ptr = 0;
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] r, int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Timeline of one transaction: grant, start when engine free, response on
  // done or after TMO waiting cycles, then GAP+1 cycles before requests count.
  initial begin : model
    bit r;
    int idx;
    int k;
    bit fin;
    forever begin
      m_tick(r);
      if (r || req == '0) continue;
      idx = rr_pick(req, m_ptr);
      m_grant = '0;
      m_grant[idx] = 1'b1;
      m_dev = req_dev_addr[7*idx +: 7];
      m_reg = req_reg_addr[8*idx +: 8];
      m_state = 2'd1;
      do begin
        m_tick(r);
      end while (!r && eng_busy);
      if (r) continue;
      m_start = 1'b1;
      m_state = 2'd2;
      fin = 1'b0;
      k = 0;
      while (!fin) begin
        m_tick(r);
        if (r) break;
        if (eng_done) begin
          m_data = eng_data; m_err = eng_nack; fin = 1'b1;
        end else if (k == TMO - 1) begin
          m_abort = 1'b1; m_data = '0; m_err = 1'b1; fin = 1'b1;
        end
        k++;
      end
      if (r) continue;
      m_rv = '0;
      m_rv[idx] = 1'b1;
      m_grant = '0;
      m_ptr = (idx + 1) % N;
      m_state = 2'd3;
      for (int g = 0; g <= GAP; g++) begin
        m_tick(r);
        if (r) break;
      end
      if (r) continue;
      m_state = 2'd0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int a_starts = 0;
  int a_aborts = 0;

  always @(posedge clock) begin
    if (eng_start === 1'b1) a_starts <= a_starts + 1;
    if (eng_abort === 1'b1) a_aborts <= a_aborts + 1;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("grant", grant, m_grant);
      check("resp_valid", resp_valid, m_rv);
      check("resp_error", resp_error, m_err);
      check("resp_data", resp_data, m_data);
      check("eng_start", eng_start, m_start);
      check("eng_abort", eng_abort, m_abort);
      check("eng_dev_addr", eng_dev_addr, m_dev);
      check("eng_reg_addr", eng_reg_addr, m_reg);
      check("state_out", state_out, m_state);
      if (|resp_valid)
        $display("txn A: resp_valid=%b error=%0b data=%h cycle=%0d", resp_valid, resp_error, resp_data, cyc);
      if (|resp_valid_b)
        $display("txn B: resp_valid=%b error=%0b data=%h abort=%0b cycle=%0d",
                 resp_valid_b, resp_error_b, resp_data_b, eng_abort_b, cyc);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reply_a(int lat, logic [15:0] d, logic nk);
    repeat (lat) @(negedge clock);
    eng_done = 1'b1; eng_data = d; eng_nack = nk;
    @(negedge clock);
    eng_done = 1'b0; eng_nack = 1'b0; eng_data = 16'hDEAD;
  endtask

  task automatic reply_b(int lat, logic [15:0] d, logic nk);
    repeat (lat) @(negedge clock);
    eng_done_b = 1'b1; eng_data_b = d; eng_nack_b = nk;
    @(negedge clock);
    eng_done_b = 1'b0; eng_nack_b = 1'b0; eng_data_b = 16'hDEAD;
  endtask

  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int t_rv, t0, t1, s0;
    for (int i = 0; i < N; i++) begin
      req_dev_addr[7*i +: 7] = 7'(16 + i);
      req_reg_addr[8*i +: 8] = 8'(160 + i);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    reset = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_state", state_out, 0);
    check("rst_grant_b", grant_b, 0);

    // Round robin from reset with all requests held.
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_for(0, 200, "rr_start");
      order[t] = onehot_idx(32'(grant));
      check("rr_dev_addr", eng_dev_addr, 32'(16 + order[t]));
      if (t == 4) req = '0;
      reply_a(10, 16'(16'h1000 + t), 1'b0);
      wait_for(1, 5, "rr_resp");
      t_rv = cyc;
      if (t < 4) begin
        wait_for(2, 200, "rr_next_grant");
        check("gap_at_least_60", 32'(cyc - t_rv >= 60), 1);
      end
    end
    for (int t = 0; t < 5; t++) check("rr_order", order[t], exp_order[t]);

    // Single request; addresses and req change after grant must not matter.
    repeat (70) @(negedge clock);
    req_dev_addr[13:7] = 7'h68;
    req_reg_addr[15:8] = 8'h3B;
    req = 4'b0010;
    @(negedge clock);
    check("single_grant", grant, 4'b0010);
    req = '0;
    req_dev_addr = '1;
    req_reg_addr = '1;
    s0 = a_starts;
    wait_for(0, 10, "single_start");
    check("single_dev", eng_dev_addr, 7'h68);
    check("single_reg", eng_reg_addr, 8'h3B);
    check("single_state_wait", state_out, 2);
    reply_a(200, 16'h1234, 1'b0);
    wait_for(1, 5, "single_resp");
    check("single_rv", resp_valid, 4'b0010);
    check("single_data", resp_data, 16'h1234);
    check("single_err", resp_error, 0);
    check("single_start_count", a_starts - s0, 1);

    // NACK response.
    repeat (70) @(negedge clock);
    req = 4'b0100;
    wait_for(0, 10, "nack_start");
    req = '0;
    reply_a(7, 16'hFFFF, 1'b1);
    wait_for(1, 5, "nack_resp");
    check("nack_rv", resp_valid, 4'b0100);
    check("nack_err", resp_error, 1);
    check("nack_data", resp_data, 16'hFFFF);
    check("nack_no_abort", a_aborts, 0);

    // Engine busy holds the start back.
    repeat (70) @(negedge clock);
    eng_busy = 1'b1;
    req = 4'b1000;
    @(negedge clock);
    check("busy_grant", grant, 4'b1000);
    s0 = a_starts;
    repeat (20) @(negedge clock);
    check("busy_no_start", a_starts - s0, 0);
    check("busy_state_issue", state_out, 1);
    eng_busy = 1'b0;
    @(negedge clock);
    check("busy_start_after_drop", eng_start, 1);
    req = '0;
    reply_a(3, 16'hA5A5, 1'b0);
    wait_for(1, 5, "busy_resp");
    check("busy_data", resp_data, 16'hA5A5);

    // Reset in the middle of WAIT.
    repeat (70) @(negedge clock);
    req = 4'b0100;
    wait_for(0, 10, "rst_mid_start");
    req = '0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_state", state_out, 0);
    check("rst_mid_data", resp_data, 0);
    check("rst_mid_dev", eng_dev_addr, 0);
    check("rst_mid_abort", eng_abort, 0);
    reset = 1'b0;
    req = 4'b0001;
    @(negedge clock);
    check("rst_mid_next_grant", grant, 4'b0001);
    wait_for(0, 10, "rst_mid_next_start");
    req = '0;
    reply_a(4, 16'h0F0F, 1'b0);
    wait_for(1, 5, "rst_mid_resp");
    check("rst_mid_resp_data", resp_data, 16'h0F0F);
    check("rst_mid_no_abort", a_aborts, 0);

    // Instance B: timeout of 100 cycles with the engine never finishing.
    repeat (5) @(negedge clock);
    req_dev_addr_b[13:7] = 7'h11;
    req_reg_addr_b[15:8] = 8'h22;
    req_b = 3'b010;
    wait_for(3, 20, "b_start");
    t0 = cyc;
    req_b = '0;
    check("b_dev", eng_dev_addr_b, 7'h11);
    check("b_reg", eng_reg_addr_b, 8'h22);
    wait_for(5, 300, "b_abort");
    t1 = cyc;
    check("b_abort_delay", t1 - t0, 100);
    check("b_tmo_rv", resp_valid_b, 3'b010);
    check("b_tmo_err", resp_error_b, 1);
    check("b_tmo_data", resp_data_b, 0);

    // Gap of zero: grant lands two cycles after resp_valid; pointer is now 2.
    req_b = 3'b111;
    @(negedge clock);
    check("b_abort_one_cycle", eng_abort_b, 0);
    check("b_no_grant_yet", grant_b, 0);
    @(negedge clock);
    check("b_grant_after_2", grant_b, 3'b100);

    // Done on the same cycle the timeout would fire: no abort, error = nack.
    wait_for(3, 10, "b_tie_start");
    reply_b(99, 16'hBEEF, 1'b1);
    check("b_tie_rv", resp_valid_b, 3'b100);
    check("b_tie_no_abort", eng_abort_b, 0);
    check("b_tie_err", resp_error_b, 1);
    check("b_tie_data", resp_data_b, 16'hBEEF);

    // Pointer wraps from 2 to 0 with three requesters.
    @(negedge clock);
    @(negedge clock);
    check("b_wrap_grant", grant_b, 3'b001);
    wait_for(3, 10, "b_wrap_start");
    reply_b(5, 16'h5555, 1'b0);
    check("b_wrap_rv", resp_valid_b, 3'b001);
    check("b_wrap_err", resp_error_b, 0);
    check("b_wrap_data", resp_data_b, 16'h5555);
    @(negedge clock);
    @(negedge clock);
    check("b_next_grant", grant_b, 3'b010);
    req_b = '0;
    wait_for(3, 10, "b_last_start");
    reply_b(2, 16'h0042, 1'b0);
    check("b_last_data", resp_data_b, 16'h0042);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_read_scheduler.md
Name: i2c_read_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one single-transaction I2C register-read engine between NUM_REQ requesters (IMU axes, config readback, etc.).
- Latches each requester's device and register address and issues one read to the engine.
- Waits for completion or timeout, then returns the data and an error flag to the requester that was granted.
- Enforces a minimum idle gap on the bus between transactions.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_DATA_BYTES, 2, bytes returned per read; engine data width = 8*NUM_DATA_BYTES
GAP_CYCLES, 60, idle clock cycles enforced between the end of one transaction and the next grant (0 allowed)
TIMEOUT_CYCLES, 65535, clock cycles allowed in WAIT before the transaction is aborted (1..65535)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  level request per requester
req_dev_addr  in  7*NUM_REQ  packed 7-bit device addresses, requester i at [7i+6:7i]
req_reg_addr  in  8*NUM_REQ  packed 8-bit register addresses, requester i at [8i+7:8i]
grant  out  NUM_REQ  one-hot, high from arbitration until response
resp_valid  out  NUM_REQ  one-cycle pulse to the granted requester
resp_error  out  1  qualified by resp_valid; 1 = NACK or timeout
resp_data  out  8*NUM_DATA_BYTES  shared response data, MSB byte first; held until next response
eng_start  out  1  one-cycle start pulse to the engine
eng_dev_addr  out  7  device address to the engine, stable from grant through completion
eng_reg_addr  out  8  register address to the engine, stable from grant through completion
eng_busy  in  1  engine mid-transaction (used only for start gating)
eng_done  in  1  one-cycle completion pulse
eng_nack  in  1  qualified by eng_done; slave failed to acknowledge
eng_data  in  8*NUM_DATA_BYTES  read data, valid with eng_done
eng_abort  out  1  one-cycle pulse on timeout; engine must return to idle and release SDA/SCL
state_out  out  2  current FSM state (debug)

Behaviour:
Reset values:
- All outputs 0.
- state = IDLE; rr pointer = 0 (requester 0 highest priority); gap and timeout counters = 0.
- Reset mid-transaction: eng_abort is NOT pulsed; the engine shares the same reset.

FSM states: IDLE=0, ISSUE=1, WAIT=2, GAP=3.

IDLE:
- If any req bit is set, select the first set bit scanning upward from rr pointer, wrapping modulo NUM_REQ.
- Latch that requester's index and addresses into eng_dev_addr/eng_reg_addr.
- Set grant[idx]; go to ISSUE.
- Latency: req sampled high in cycle N -> grant high in N+1.

ISSUE:
- If eng_busy=0: pulse eng_start for 1 cycle, clear timeout counter, go to WAIT.
- If eng_busy=1: hold in ISSUE and wait.

WAIT (timeout counter increments each cycle):
- On eng_done:
  - resp_data <= eng_data; resp_error <= eng_nack.
  - Pulse resp_valid[idx] the next cycle; clear grant.
  - rr pointer <= idx+1 (wraps).
  - Go to GAP.
- On counter == TIMEOUT_CYCLES-1 without eng_done:
  - Pulse eng_abort.
  - resp_data <= 0; resp_error <= 1; pulse resp_valid[idx].
  - Same grant/pointer update as eng_done; go to GAP.
- eng_done and timeout in the same cycle: eng_done wins; no abort.
- eng_done outside WAIT is ignored.

GAP:
- Count GAP_CYCLES cycles, then go to IDLE.
- GAP_CYCLES=0: go to IDLE the next cycle.
- Requests are not granted during GAP.

Requester rules:
- Addresses are sampled only at grant; later changes have no effect on the current transaction.
- Dropping req while granted does not cancel; the transaction completes and resp_valid still pulses.
- Fairness: no requester waits more than NUM_REQ-1 transactions once its req is held.

Width rules:
- Counter widths sized from the parameters (gap counter >= clog2(GAP_CYCLES+1), timeout counter 16 bits).
- rr pointer is clog2(NUM_REQ) bits, wrapping at NUM_REQ (not a power of two).

Test Plan:
- Single request: req=4'b0010, dev=7'h68, reg=8'h3B; engine returns done after 200 cycles with data 16'h1234, nack=0 -> grant=4'b0010 one cycle after req, eng_start pulses once, eng_dev_addr=7'h68, eng_reg_addr=8'h3B, resp_valid=4'b0010 pulse, resp_data=16'h1234, resp_error=0.
- Round robin: req=4'b1111 held, engine done after 10 cycles each -> grant order 0,1,2,3,0.
- Gap timing: at least 60 cycles from resp_valid to the next grant. With GAP_CYCLES=0, grant follows resp_valid by 2 cycles.
- NACK: engine done with nack=1, data=16'hFFFF -> resp_error=1, resp_data=16'hFFFF, no eng_abort.
- Timeout: TIMEOUT_CYCLES=100, engine never finishes -> eng_abort pulse exactly 100 cycles after eng_start, resp_valid with error=1 and data=0. Variant: done and timeout in the same cycle -> no abort, error=eng_nack.
- Reset mid-WAIT, then req=4'b0001 -> all outputs 0 the cycle after reset; next grant goes to requester 0 with no eng_abort. Separately, eng_busy=1 at ISSUE delays eng_start until busy drops.
